demux_16_tdm: RTL and testbench

Time-division 1:16 demultiplexer: the receiving end of the 16:1 select-driven multiplexer path. Takes the serial stream produced by a mux scanning inputs i0..i15 (slot 0 first). Each accepted bit is steered to the lane selected by an internal 4-bit slot counter. Complete 16-lane frames are presented in parallel with a valid/ready handshake. The block sits downstream of the 16:1 mux tree and re-creates the parallel i0..i15 word.

---
 rtl/demux_16_tdm_pkg.sv | 10 +
 rtl/demux_16_tdm_if.sv | 27 ++
 rtl/demux_16_tdm_slot_cnt.sv | 37 +++
 rtl/demux_16_tdm.sv | 98 +++++++++
 tb/tb_demux_16_tdm.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/demux_16_tdm_pkg.sv
// Shared constants and state encoding for the 1:16 TDM demultiplexer.
package demux_pkg;
   localparam int LANES = 16;
   localparam int SEL_W = 4;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_e;
endpackage

// File: rtl/demux_16_tdm_if.sv
// Serial-in / parallel-frame-out bundle; master is the stream source plus frame consumer.
interface demux_16_tdm_if
   import demux_pkg::*;
#(
   parameter int LANES_P = LANES,
   parameter int SEL_W_P = SEL_W
);
   logic               din;
   logic               din_valid;
   logic               sync;
   logic [LANES_P-1:0] frame;
   logic               frame_valid;
   logic               frame_ready;
   logic [SEL_W_P-1:0] slot;
   logic               overrun;
   logic               sync_err;

   modport master (
      output din, din_valid, sync, frame_ready,
      input  frame, frame_valid, slot, overrun, sync_err
   );

   modport slave (
      input  din, din_valid, sync, frame_ready,
      output frame, frame_valid, slot, overrun, sync_err
   );
endinterface

// File: rtl/demux_16_tdm_slot_cnt.sv
// Slot counter: load-to-1 on sync, increment on accepted bit, wraps modulo 2^SEL_W.
module slot_cnt
   import demux_pkg::*;
#(
   parameter int LANES_P = LANES,
   parameter int SEL_W_P = SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               inc_i,
   output logic [SEL_W_P-1:0] slot_o,
   output logic               last_o
);
   logic [SEL_W_P-1:0] slot_q;
   logic [SEL_W_P-1:0] slot_d;

   always_comb begin
      slot_d = slot_q;
      if (load_i) begin
         slot_d = SEL_W_P'(1);
      end else if (inc_i) begin
         slot_d = slot_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;
   assign last_o = inc_i && (slot_q == SEL_W_P'(LANES_P - 1));
endmodule

// File: rtl/demux_16_tdm.sv
// 1:16 time-division demultiplexer: steers serial bits into lanes and hands
// completed frames to the consumer over a valid/ready handshake.
module demux_16_tdm
#(
   parameter int LANES = demux_pkg::LANES,
   parameter int SEL_W = demux_pkg::SEL_W
) (
   input logic             clk,
   input logic             rst,
   demux_16_tdm_if.slave   bus
);
   import demux_pkg::*;

   state_e             state_q, state_d;
   logic [LANES-1:0]   asm_q, asm_d;
   logic [LANES-1:0]   frame_q, frame_d;
   logic               fv_q, fv_d;
   logic               ovr_q, ovr_d;
   logic               serr_q, serr_d;

   logic               cnt_load;
   logic               cnt_inc;
   logic               cnt_last;
   logic [SEL_W-1:0]   slot;

   // A sync is honoured in any state; plain bits only count once aligned.
   assign cnt_load = bus.din_valid && bus.sync;
   assign cnt_inc  = bus.din_valid && !bus.sync && (state_q == COLLECT);

   slot_cnt #(
      .LANES_P (LANES),
      .SEL_W_P (SEL_W)
   ) u_slot_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .slot_o (slot),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      asm_d   = asm_q;
      frame_d = frame_q;
      fv_d    = fv_q;
      ovr_d   = ovr_q;
      serr_d  = 1'b0;

      if (fv_q && bus.frame_ready) begin
         fv_d = 1'b0;
      end

      if (cnt_load) begin
         asm_d    = '0;
         asm_d[0] = bus.din;
         state_d  = COLLECT;
         if (state_q == COLLECT && slot != '0) begin
            serr_d = 1'b1;
         end
      end else if (cnt_inc) begin
         asm_d[slot] = bus.din;
         // A completion may load into a slot being consumed this same cycle.
         if (cnt_last) begin
            if (!fv_q || bus.frame_ready) begin
               frame_d = asm_d;
               fv_d    = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         asm_q   <= '0;
         frame_q <= '0;
         fv_q    <= 1'b0;
         ovr_q   <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         asm_q   <= asm_d;
         frame_q <= frame_d;
         fv_q    <= fv_d;
         ovr_q   <= ovr_d;
         serr_q  <= serr_d;
      end
   end

   assign bus.frame       = frame_q;
   assign bus.frame_valid = fv_q;
   assign bus.slot        = slot;
   assign bus.overrun     = ovr_q;
   assign bus.sync_err    = serr_q;
endmodule

// File: tb/tb_demux_16_tdm.sv
// Directed bench for demux_16_tdm: framing, handshake, overrun, resync and reset.
module tb_demux_16_tdm;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   demux_16_tdm_if #(.LANES_P(16), .SEL_W_P(4)) bus ();

   demux_16_tdm #(.LANES(16), .SEL_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic v, input logic d, input logic s);
      bus.din_valid = v;
      bus.din       = d;
      bus.sync      = s;
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      bus.sync      = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] w, input logic with_sync);
      for (int k = 0; k < 16; k++) begin
         step(1'b1, w[k], (k == 0) && with_sync);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.frame_ready = 1'b0;
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      checks += 5;
      if (bus.frame !== 16'h0000) begin errors++; $display("FAIL reset_frame got=%h exp=0000", bus.frame); end
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
      if (bus.slot !== 4'd0) begin errors++; $display("FAIL reset_slot got=%0d exp=0", bus.slot); end
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
      if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got=%b exp=0", bus.sync_err); end
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single_frame();
      logic [15:0] w;
      w = 16'hA5C3;
      bus.frame_ready = 1'b1;
      step(1'b1, w[0], 1'b1);
      checks++;
      if (bus.slot !== 4'd1) begin errors++; $display("FAIL single_slot1 got=%0d exp=1", bus.slot); end
      for (int k = 1; k < 15; k++) step(1'b1, w[k], 1'b0);
      checks++;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL single_early_fv got=%b exp=0", bus.frame_valid); end
      step(1'b1, w[15], 1'b0);
      checks += 3;
      if (bus.frame !== 16'hA5C3) begin errors++; $display("FAIL single_frame got=%h exp=a5c3", bus.frame); end
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL single_fv got=%b exp=1", bus.frame_valid); end
      if (bus.slot !== 4'd0) begin errors++; $display("FAIL single_slot_wrap got=%0d exp=0", bus.slot); end
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL single_fv_clear got=%b exp=0", bus.frame_valid); end
      $display("test_single_frame frame=%h", bus.frame);
   endtask

   task automatic test_overrun();
      bus.frame_ready = 1'b0;
      send_frame(16'h1234, 1'b1);
      checks += 3;
      if (bus.frame !== 16'h1234) begin errors++; $display("FAIL ovr_first_frame got=%h exp=1234", bus.frame); end
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_fv got=%b exp=1", bus.frame_valid); end
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", bus.overrun); end
      send_frame(16'hFFFF, 1'b0);
      checks += 3;
      if (bus.frame !== 16'h1234) begin errors++; $display("FAIL ovr_held_frame got=%h exp=1234", bus.frame); end
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_fv got=%b exp=1", bus.frame_valid); end
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
      bus.frame_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      checks += 2;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_fv_clear got=%b exp=0", bus.frame_valid); end
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
      $display("test_overrun overrun=%b", bus.overrun);
   endtask

   task automatic test_sync_err();
      logic [15:0] w;
      w = 16'h3C41;
      bus.frame_ready = 1'b1;
      step(1'b1, 1'b0, 1'b1);
      for (int k = 1; k < 6; k++) step(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.slot !== 4'd6) begin errors++; $display("FAIL serr_pre_slot got=%0d exp=6", bus.slot); end
      step(1'b1, w[0], 1'b1);
      checks += 2;
      if (bus.sync_err !== 1'b1) begin errors++; $display("FAIL serr_pulse got=%b exp=1", bus.sync_err); end
      if (bus.slot !== 4'd1) begin errors++; $display("FAIL serr_slot got=%0d exp=1", bus.slot); end
      step(1'b1, w[1], 1'b0);
      checks++;
      if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL serr_one_cycle got=%b exp=0", bus.sync_err); end
      for (int k = 2; k < 15; k++) step(1'b1, w[k], 1'b0);
      checks++;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL serr_early_fv got=%b exp=0", bus.frame_valid); end
      step(1'b1, w[15], 1'b0);
      checks += 2;
      if (bus.frame !== 16'h3C41) begin errors++; $display("FAIL serr_frame got=%h exp=3c41", bus.frame); end
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL serr_fv got=%b exp=1", bus.frame_valid); end
      step(1'b0, 1'b0, 1'b0);
      $display("test_sync_err frame=%h", bus.frame);
   endtask

   task automatic test_gapped();
      logic [15:0] w;
      logic [3:0]  exp_slot;
      w = 16'h00FF;
      bus.frame_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step(1'b1, w[k], k == 0);
         if (k == 15) begin
            checks += 2;
            if (bus.frame !== 16'h00FF) begin errors++; $display("FAIL gap_frame got=%h exp=00ff", bus.frame); end
            if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL gap_fv got=%b exp=1", bus.frame_valid); end
         end
         // Idle cycle carries garbage data and a stray sync that must be ignored.
         step(1'b0, ~w[k], 1'b1);
         exp_slot = 4'(k + 1);
         checks++;
         if (bus.slot !== exp_slot) begin errors++; $display("FAIL gap_slot k=%0d got=%0d exp=%0d", k, bus.slot, exp_slot); end
      end
      $display("test_gapped done");
   endtask

   task automatic test_reset_mid();
      bus.frame_ready = 1'b1;
      send_frame(16'hFFFF, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      for (int k = 1; k < 9; k++) step(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.slot !== 4'd9) begin errors++; $display("FAIL rmid_pre_slot got=%0d exp=9", bus.slot); end
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      checks += 3;
      if (bus.slot !== 4'd0) begin errors++; $display("FAIL rmid_slot got=%0d exp=0", bus.slot); end
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got=%b exp=0", bus.overrun); end
      if (bus.frame !== 16'h0000) begin errors++; $display("FAIL rmid_frame got=%h exp=0000", bus.frame); end
      send_frame(16'hFFFF, 1'b0);
      checks += 2;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL rmid_nosync_fv got=%b exp=0", bus.frame_valid); end
      if (bus.slot !== 4'd0) begin errors++; $display("FAIL rmid_nosync_slot got=%0d exp=0", bus.slot); end
      send_frame(16'h8001, 1'b1);
      checks += 2;
      if (bus.frame !== 16'h8001) begin errors++; $display("FAIL rmid_frame2 got=%h exp=8001", bus.frame); end
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL rmid_fv2 got=%b exp=1", bus.frame_valid); end
      step(1'b0, 1'b0, 1'b0);
      $display("test_reset_mid frame=%h", bus.frame);
   endtask

   task automatic test_back_to_back();
      logic [15:0] w;
      w = 16'h2222;
      bus.frame_ready = 1'b0;
      send_frame(16'h1111, 1'b1);
      checks++;
      if (bus.frame !== 16'h1111) begin errors++; $display("FAIL b2b_first got=%h exp=1111", bus.frame); end
      for (int k = 0; k < 15; k++) step(1'b1, w[k], 1'b0);
      bus.frame_ready = 1'b1;
      step(1'b1, w[15], 1'b0);
      checks += 3;
      if (bus.frame !== 16'h2222) begin errors++; $display("FAIL b2b_frame got=%h exp=2222", bus.frame); end
      if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_fv got=%b exp=1", bus.frame_valid); end
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL b2b_fv_clear got=%b exp=0", bus.frame_valid); end
      $display("test_back_to_back frame=%h", bus.frame);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.din = 1'b0;
      bus.din_valid = 1'b0;
      bus.sync = 1'b0;
      bus.frame_ready = 1'b0;
      test_reset();
      test_single_frame();
      test_overrun();
      test_sync_err();
      test_gapped();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
